exception_unit: RTL and testbench

Sequences entry into an exception handler for the multicycle MIPS datapath. It sits directly upstream of the 7-input PC-source mux. When an exception is flagged, it does four things: saves EPC, reads the handler-address byte from the exception vector (253/254/255), and drives the PC-source select plus a PC write to redirect fetch. It stalls the control unit with `busy` for the whole sequence.

---
 rtl/exc_pkg.sv | 24 ++
 rtl/exc_priority_enc.sv | 22 ++
 rtl/exception_unit.sv | 91 +++++++++
 tb/tb_exception_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared states, cause codes, vector addresses and PC-mux selector encodings
package exc_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_EPC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_LOAD_PC
  } state_t;
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_DIV    = 2'd3;
  localparam logic [31:0] VEC_ADDR_OPCODE = 32'd253;
  localparam logic [31:0] VEC_ADDR_OVF    = 32'd254;
  localparam logic [31:0] VEC_ADDR_DIV    = 32'd255;
  localparam logic [2:0] PC_SRC_SEQ     = 3'b000;
  localparam logic [2:0] PC_SRC_BRANCH  = 3'b001;
  localparam logic [2:0] PC_SRC_ALUOUT  = 3'b010;
  localparam logic [2:0] PC_SRC_JUMP    = 3'b011;
  localparam logic [2:0] PC_SRC_JR      = 3'b100;
  localparam logic [2:0] PC_SRC_HANDLER = 3'b101;
  localparam logic [2:0] PC_SRC_EPC     = 3'b110;
endpackage

// File: rtl/exc_priority_enc.sv
// exc_priority_enc: picks the highest-priority exception flag (opcode > overflow > divzero)
module exc_priority_enc
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE = VEC_ADDR_OPCODE,
  parameter logic [31:0] VEC_OVF    = VEC_ADDR_OVF,
  parameter logic [31:0] VEC_DIV    = VEC_ADDR_DIV
) (
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  output logic        valid,
  output logic [1:0]  cause,
  output logic [31:0] vec
);
  // lower-priority flags are simply masked by the ternary chain
  always_comb begin
    valid = exc_opcode | exc_overflow | exc_divzero;
    cause = exc_opcode ? CAUSE_OPCODE : exc_overflow ? CAUSE_OVF : exc_divzero ? CAUSE_DIV : CAUSE_NONE;
    vec   = exc_opcode ? VEC_OPCODE : exc_overflow ? VEC_OVF : exc_divzero ? VEC_DIV : 32'd0;
  end
endmodule

// File: rtl/exception_unit.sv
// exception_unit: saves EPC, fetches the handler byte from the exception vector and redirects the PC
module exception_unit
  import exc_pkg::*;
#(
  parameter int          MEM_LATENCY    = 1,
  parameter logic [31:0] VEC_OPCODE     = exc_pkg::VEC_ADDR_OPCODE,
  parameter logic [31:0] VEC_OVF        = exc_pkg::VEC_ADDR_OVF,
  parameter logic [31:0] VEC_DIV        = exc_pkg::VEC_ADDR_DIV,
  parameter logic [2:0]  PC_SRC_HANDLER = exc_pkg::PC_SRC_HANDLER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] handler_addr,
  output logic [2:0]  pc_src,
  output logic        pc_write,
  output logic [1:0]  cause,
  output logic        busy
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic hit;
  logic [1:0] hit_cause;
  logic [31:0] hit_vec;
  logic unused_mem_hi;
  assign unused_mem_hi = &{1'b0, mem_data_in[31:8]};
  exc_priority_enc #(
    .VEC_OPCODE(VEC_OPCODE),
    .VEC_OVF   (VEC_OVF),
    .VEC_DIV   (VEC_DIV)
  ) u_enc (
    .exc_opcode  (exc_opcode),
    .exc_overflow(exc_overflow),
    .exc_divzero (exc_divzero),
    .valid       (hit),
    .cause       (hit_cause),
    .vec         (hit_vec)
  );
  // state register; an asynchronous reset aborts any sequence in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= next;
  // next-state: flags only matter in IDLE, MEM_WAIT leaves once the latency counter drains
  always_comb begin
    next = state;
    case (state)
      S_IDLE:     next = hit ? S_SAVE_EPC : S_IDLE;
      S_SAVE_EPC: next = S_MEM_REQ;
      S_MEM_REQ:  next = S_MEM_WAIT;
      S_MEM_WAIT: next = (cnt == '0) ? S_LOAD_PC : S_MEM_WAIT;
      S_LOAD_PC:  next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end
  // strobes decode straight from the state register, so reset clears them immediately
  always_comb begin
    mem_rd    = state == S_MEM_REQ;
    epc_write = state == S_SAVE_EPC;
    pc_write  = state == S_LOAD_PC;
    pc_src    = (state == S_LOAD_PC) ? PC_SRC_HANDLER : PC_SRC_SEQ;
  end
  // latched cause/vector/EPC on entry, latency counter and handler byte capture
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cause        <= CAUSE_NONE;
      mem_addr     <= '0;
      epc_out      <= '0;
      handler_addr <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
    end else begin
      busy <= next != S_IDLE;
      if (state == S_IDLE && hit) begin
        cause    <= hit_cause;
        mem_addr <= hit_vec;
        epc_out  <= pc_in - 32'd4;
      end
      if (state == S_MEM_REQ) cnt <= CW'(MEM_LATENCY - 1);
      if (state == S_MEM_WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state == S_MEM_WAIT && cnt == '0) handler_addr <= {24'b0, mem_data_in[7:0]};
    end
endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: table-driven entry sequences plus reset, filtering and latency corner cases
module tb_exception_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic exc_opcode = 0, exc_overflow = 0, exc_divzero = 0;
  logic o3 = 0, v3 = 0, d3 = 0;
  logic [31:0] pc_in = '0, mem_data_in = '0;
  logic [31:0] mem_addr, epc_out, handler_addr, mem_addr3, epc_out3, handler_addr3;
  logic mem_rd, epc_write, pc_write, busy, mem_rd3, epc_write3, pc_write3, busy3;
  logic [2:0] pc_src, pc_src3;
  logic [1:0] cause, cause3;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .pc_in(pc_in), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .epc_out(epc_out), .epc_write(epc_write), .handler_addr(handler_addr),
    .pc_src(pc_src), .pc_write(pc_write), .cause(cause), .busy(busy)
  );

  exception_unit #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .exc_opcode(o3), .exc_overflow(v3),
    .exc_divzero(d3), .pc_in(pc_in), .mem_data_in(mem_data_in), .mem_addr(mem_addr3),
    .mem_rd(mem_rd3), .epc_out(epc_out3), .epc_write(epc_write3), .handler_addr(handler_addr3),
    .pc_src(pc_src3), .pc_write(pc_write3), .cause(cause3), .busy(busy3)
  );

  typedef struct {
    logic [2:0]  flags;
    logic [31:0] pc, data;
    logic [1:0]  cause;
    logic [31:0] vec, epc, hnd;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " mem_rd"}, 32'(mem_rd), 0);
    chk({tag, " epc_write"}, 32'(epc_write), 0);
    chk({tag, " pc_write"}, 32'(pc_write), 0);
    chk({tag, " pc_src"}, 32'(pc_src), 0);
    chk({tag, " cause"}, 32'(cause), 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " epc_out"}, epc_out, 0);
    chk({tag, " handler_addr"}, handler_addr, 0);
  endtask

  initial begin
    int n_busy, n_rd, pcw_at, bad_addr, stray;
    tv[0] = '{3'b010, 32'h40,   32'h000000A7, 2'd2, 32'd254, 32'h3C,       32'hA7};
    tv[1] = '{3'b101, 32'h100,  32'hFFFFFF12, 2'd1, 32'd253, 32'hFC,       32'h12};
    tv[2] = '{3'b001, 32'h0,    32'h00000055, 2'd3, 32'd255, 32'hFFFFFFFC, 32'h55};
    tv[3] = '{3'b111, 32'h1000, 32'h12345680, 2'd1, 32'd253, 32'hFFC,      32'h80};
    tv[4] = '{3'b011, 32'h8,    32'hABCDEF01, 2'd2, 32'd254, 32'h4,        32'h01};

    #3;
    chk_idle_zero("reset");
    chk("reset busy3", 32'(busy3), 0);
    tick();
    reset = 1'b1;
    tick();
    chk_idle_zero("post-reset idle");

    for (int i = 0; i < 5; i++) begin
      pc_in = tv[i].pc;
      mem_data_in = tv[i].data;
      {exc_opcode, exc_overflow, exc_divzero} = tv[i].flags;
      tick();
      {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
      pc_in = 32'hDEAD0000;
      chk($sformatf("v%0d save busy", i), 32'(busy), 1);
      chk($sformatf("v%0d save epc_write", i), 32'(epc_write), 1);
      chk($sformatf("v%0d save epc_out", i), epc_out, tv[i].epc);
      chk($sformatf("v%0d save cause", i), 32'(cause), 32'(tv[i].cause));
      chk($sformatf("v%0d save mem_rd", i), 32'(mem_rd), 0);
      tick();
      chk($sformatf("v%0d req mem_rd", i), 32'(mem_rd), 1);
      chk($sformatf("v%0d req mem_addr", i), mem_addr, tv[i].vec);
      chk($sformatf("v%0d req epc_write", i), 32'(epc_write), 0);
      tick();
      chk($sformatf("v%0d wait mem_rd", i), 32'(mem_rd), 0);
      chk($sformatf("v%0d wait mem_addr", i), mem_addr, tv[i].vec);
      chk($sformatf("v%0d wait busy", i), 32'(busy), 1);
      tick();
      chk($sformatf("v%0d load pc_write", i), 32'(pc_write), 1);
      chk($sformatf("v%0d load pc_src", i), 32'(pc_src), 32'b101);
      chk($sformatf("v%0d load handler", i), handler_addr, tv[i].hnd);
      chk($sformatf("v%0d load busy", i), 32'(busy), 1);
      tick();
      chk($sformatf("v%0d idle busy", i), 32'(busy), 0);
      chk($sformatf("v%0d idle pc_write", i), 32'(pc_write), 0);
      chk($sformatf("v%0d idle pc_src", i), 32'(pc_src), 0);
      chk($sformatf("v%0d idle handler hold", i), handler_addr, tv[i].hnd);
      chk($sformatf("v%0d idle cause hold", i), 32'(cause), 32'(tv[i].cause));
      chk($sformatf("v%0d idle epc hold", i), epc_out, tv[i].epc);
    end

    // flag raised while busy, held through the edge that leaves LOAD_PC
    pc_in = 32'h200;
    mem_data_in = 32'h33;
    exc_overflow = 1'b1;
    tick();
    exc_overflow = 1'b0;
    exc_opcode = 1'b1;
    tick();
    tick();
    tick();
    chk("filter load pc_write", 32'(pc_write), 1);
    tick();
    exc_opcode = 1'b0;
    chk("filter idle busy", 32'(busy), 0);
    chk("filter idle epc_write", 32'(epc_write), 0);
    tick();
    chk("filter no restart busy", 32'(busy), 0);
    chk("filter cause kept", 32'(cause), 2);
    chk("filter epc kept", epc_out, 32'h1FC);

    // asynchronous reset during MEM_WAIT
    pc_in = 32'h300;
    exc_overflow = 1'b1;
    tick();
    exc_overflow = 1'b0;
    tick();
    tick();
    chk("pre-reset in wait", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk_idle_zero("async reset");
    tick();
    reset = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (pc_write || epc_write || busy) stray++;
    end
    chk("after reset stray strobes", 32'(stray), 0);

    // MEM_LATENCY=3 instance
    pc_in = 32'h500;
    mem_data_in = 32'h000000C4;
    o3 = 1'b1;
    n_busy = 0; n_rd = 0; pcw_at = -1; bad_addr = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      o3 = 1'b0;
      if (busy3) n_busy++;
      if (mem_rd3) n_rd++;
      if (pc_write3) pcw_at = c;
      if (busy3 && !epc_write3 && mem_addr3 !== 32'd253) bad_addr++;
    end
    chk("lat3 busy cycles", 32'(n_busy), 6);
    chk("lat3 mem_rd cycles", 32'(n_rd), 1);
    chk("lat3 pc_write cycle", 32'(pcw_at), 5);
    chk("lat3 addr unstable", 32'(bad_addr), 0);
    chk("lat3 handler", handler_addr3, 32'hC4);
    chk("lat3 epc", epc_out3, 32'h4FC);
    chk("lat3 cause", 32'(cause3), 1);
    chk("lat3 dut1 untouched", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
